seg14_scan_decoder: RTL and testbench
=====================================

Name: seg14_scan_decoder

Overview:
Receive-side counterpart of the 12-digit multiplexed 14-segment display driver. It samples the driver's one-hot digit select and segment bus, decodes each segment pattern back to a character code, and assembles complete 12-digit frames. A frame commits to a readable buffer only when its digits arrive in strict scan order. It sits beside the driver, or on a board-level loopback, as a self-check and observability block.

Parameters:
NUM_DIGITS, 12, number of scanned digits; select width and frame length.
CODE_W, 6, character code width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
sel  input  NUM_DIGITS  one-hot digit select from the scan driver.
segm  input  14  segment pattern for the selected digit.
rd_addr  input  4  digit index to read, 0..NUM_DIGITS-1.
rd_data  output  CODE_W  character code of the committed frame at rd_addr.
frame_valid  output  1  one-cycle pulse when a complete frame commits.
seq_err  output  1  one-cycle pulse on a scan-order or select-encoding violation.
unk_seen  output  1  sticky flag: the committed frame contains an unknown pattern.
msg_match  output  1  committed frame equals EXPECT_MSG (optional feature).

Behaviour:
- Reset: clk is the only clock; rst is synchronous, active-high. On reset:
  - state = HUNT.
  - Input registers, shadow buffer and committed buffer are cleared to CODE_SPACE.
  - rd_data = CODE_SPACE; frame_valid = seq_err = unk_seen = msg_match = 0.
- Input stage: sel and segm are registered once (stage S1). All decisions use the S1 values.
- Select classification of S1 sel:
  - all-zero = idle: ignored, state unchanged.
  - exactly one bit set = valid; idx = the bit position.
  - anything else = invalid.
- Decode: a combinational lookup maps segm to a code.
  - Codes: '0'-'9' = 0-9, 'A'-'Z' = 10-35, 'Ñ' = 36, space (all-zero pattern) = 37, any other pattern = CODE_UNKNOWN (63).
  - Pattern 10110111000000 is shared by 'S' and '5' and decodes to 5.
- FSM states: HUNT, ASSEMBLE. Variables: last_idx, held_seg.
  - HUNT:
    - valid idx = 0: write shadow[0], last_idx = 0, go to ASSEMBLE.
    - any other valid idx: ignored, no error.
    - invalid sel: seq_err pulse, stay in HUNT.
  - ASSEMBLE:
    - idx == last_idx with the same segm: ignored (slower scan rates are tolerated).
    - idx == last_idx with a different segm: overwrite shadow[idx].
    - idx == last_idx+1: write shadow[idx], last_idx = idx.
    - idx == NUM_DIGITS-1 reached in order: on the same edge, copy shadow to the committed buffer, including the decode of digit 11. frame_valid pulses in the following cycle. Go to HUNT.
    - any other valid idx, or an invalid sel: seq_err pulse, discard the shadow, go to HUNT. If that idx is 0, immediately restart as in HUNT.
    - idle: ignored.
- Latency: sel/segm present in cycle N, registered in S1 at the end of N, decoded and written at the end of N+1. For digit 11, frame_valid is high during cycle N+2 and new rd_data is readable from N+2.
- Read port: rd_data is registered, one-cycle latency from rd_addr. rd_addr >= NUM_DIGITS returns CODE_SPACE.
- The committed buffer changes only on commit; a partial frame is never visible.
- unk_seen is recomputed at each commit (OR over the 12 codes == 63) and is cleared only by rst or by a clean commit.
- Simultaneous events: a commit and a rd_addr read in the same cycle return the pre-commit data; the new data appears the next cycle.
- rst mid-frame: the shadow is discarded and no frame_valid is issued.

Optional Feature:
SEG14_MSG_MATCH_EN
- Defined: at each commit, msg_match is registered as (committed frame == EXPECT_MSG) and holds until the next commit or rst.
- Undefined: the compare logic is omitted and msg_match is tied to 0.

Decomposition:
- Package seg14_pkg:
  - 14-bit segment pattern constants.
  - Code constants CODE_SPACE (37) and CODE_UNKNOWN (63).
  - state enum {HUNT, ASSEMBLE}.
  - EXPECT_MSG = "BROTHING1201" as 12 codes.
- Sub-module seg14_char_decode: combinational 14-bit to CODE_W lookup, reusable by other display blocks.

Test Plan:
- Reset, then scan idx 0..11 with the patterns for B,R,O,T,H,I,N,G,1,2,0,1:
  - frame_valid pulses once, two cycles after digit 11.
  - rd_addr=0 returns 11 and rd_addr=8 returns 1.
  - msg_match=1 with the macro defined, 0 without; unk_seen=0.
- Scan 0,1,2 then jump to 5: seq_err pulses, there is no frame_valid, and the committed buffer is unchanged. A following full clean scan commits normally.
- Drive sel=000000000011 mid-frame: seq_err pulse and return to HUNT. sel=0 for 10 cycles mid-frame: no error, and the frame completes afterwards.
- Hold each digit for 3 cycles (slow scan): exactly one frame_valid per 12 digits, with correct codes.
- Digit 4 carries pattern 00000000000001: the frame commits with rd_data[4]=63 and unk_seen=1. A next clean frame clears unk_seen.
- Assert rst while at digit 6: all outputs return to reset values, no frame_valid, rd_data=37 for every address.

Source files
------------

// File: rtl/seg14_pkg.sv
// seg14_pkg: shared constants for the 14-segment scan decoder.
// Segment bit order, MSB first: a b c d e f g1 g2 h i j k l m
//   a..f : outer segments, g1/g2 : middle halves,
//   h : top-left diagonal, i : top vertical, j : top-right diagonal,
//   k : bottom-left diagonal, l : bottom vertical, m : bottom-right diagonal.
package seg14_pkg;

  typedef logic [5:0]  code_t;
  typedef logic [13:0] seg_t;

  localparam code_t CODE_NTILDE  = 6'd36;
  localparam code_t CODE_SPACE   = 6'd37;
  localparam code_t CODE_UNKNOWN = 6'd63;

  localparam seg_t SEG_BLANK  = 14'b00000000000000;
  localparam seg_t SEG_0      = 14'b11111100001100;
  localparam seg_t SEG_1      = 14'b01100000001000;
  localparam seg_t SEG_2      = 14'b11011011000000;
  localparam seg_t SEG_3      = 14'b11110001000000;
  localparam seg_t SEG_4      = 14'b01100111000000;
  localparam seg_t SEG_5      = 14'b10110111000000;
  localparam seg_t SEG_6      = 14'b10111111000000;
  localparam seg_t SEG_7      = 14'b11100000000000;
  localparam seg_t SEG_8      = 14'b11111111000000;
  localparam seg_t SEG_9      = 14'b11110111000000;
  localparam seg_t SEG_A      = 14'b11101111000000;
  localparam seg_t SEG_B      = 14'b11110001010010;
  localparam seg_t SEG_C      = 14'b10011100000000;
  localparam seg_t SEG_D      = 14'b11110000010010;
  localparam seg_t SEG_E      = 14'b10011110000000;
  localparam seg_t SEG_F      = 14'b10001110000000;
  localparam seg_t SEG_G      = 14'b10111101000000;
  localparam seg_t SEG_H      = 14'b01101111000000;
  localparam seg_t SEG_I      = 14'b10010000010010;
  localparam seg_t SEG_J      = 14'b01111000000000;
  localparam seg_t SEG_K      = 14'b00001110001001;
  localparam seg_t SEG_L      = 14'b00011100000000;
  localparam seg_t SEG_M      = 14'b01101100101000;
  localparam seg_t SEG_N      = 14'b01101100100001;
  localparam seg_t SEG_O      = 14'b11111100000000;
  localparam seg_t SEG_P      = 14'b11001111000000;
  localparam seg_t SEG_Q      = 14'b11111100000001;
  localparam seg_t SEG_R      = 14'b11001111000001;
  localparam seg_t SEG_S      = SEG_5;
  localparam seg_t SEG_T      = 14'b10000000010010;
  localparam seg_t SEG_U      = 14'b01111100000000;
  localparam seg_t SEG_V      = 14'b00001100001100;
  localparam seg_t SEG_W      = 14'b01101100000101;
  localparam seg_t SEG_X      = 14'b00000000101101;
  localparam seg_t SEG_Y      = 14'b00000000101010;
  localparam seg_t SEG_Z      = 14'b10010000001100;
  localparam seg_t SEG_NTILDE = 14'b11101100100001;

  typedef enum logic [0:0] {HUNT, ASSEMBLE} state_t;

  // "BROTHING1201", digit 0 first
  localparam logic [0:11][5:0] EXPECT_MSG = {
    6'd11, 6'd27, 6'd24, 6'd29, 6'd17, 6'd18,
    6'd23, 6'd16, 6'd1,  6'd2,  6'd0,  6'd1
  };

endpackage

// File: rtl/seg14_char_decode.sv
// seg14_char_decode: combinational 14-segment pattern to character code lookup.
// 'S' and '5' light the same segments; that pattern decodes to 5.
module seg14_char_decode
  import seg14_pkg::*;
#(
  parameter int CODE_W = 6
) (
  input  logic [13:0]       i_segm,
  output logic [CODE_W-1:0] o_code
);

  // Pattern lookup; anything not in the font reads back as unknown
  always_comb begin
    o_code = CODE_W'(CODE_UNKNOWN);
    case (i_segm)
      SEG_BLANK:  o_code = CODE_W'(CODE_SPACE);
      SEG_0:      o_code = CODE_W'(0);
      SEG_1:      o_code = CODE_W'(1);
      SEG_2:      o_code = CODE_W'(2);
      SEG_3:      o_code = CODE_W'(3);
      SEG_4:      o_code = CODE_W'(4);
      SEG_5:      o_code = CODE_W'(5);
      SEG_6:      o_code = CODE_W'(6);
      SEG_7:      o_code = CODE_W'(7);
      SEG_8:      o_code = CODE_W'(8);
      SEG_9:      o_code = CODE_W'(9);
      SEG_A:      o_code = CODE_W'(10);
      SEG_B:      o_code = CODE_W'(11);
      SEG_C:      o_code = CODE_W'(12);
      SEG_D:      o_code = CODE_W'(13);
      SEG_E:      o_code = CODE_W'(14);
      SEG_F:      o_code = CODE_W'(15);
      SEG_G:      o_code = CODE_W'(16);
      SEG_H:      o_code = CODE_W'(17);
      SEG_I:      o_code = CODE_W'(18);
      SEG_J:      o_code = CODE_W'(19);
      SEG_K:      o_code = CODE_W'(20);
      SEG_L:      o_code = CODE_W'(21);
      SEG_M:      o_code = CODE_W'(22);
      SEG_N:      o_code = CODE_W'(23);
      SEG_O:      o_code = CODE_W'(24);
      SEG_P:      o_code = CODE_W'(25);
      SEG_Q:      o_code = CODE_W'(26);
      SEG_R:      o_code = CODE_W'(27);
      SEG_T:      o_code = CODE_W'(29);
      SEG_U:      o_code = CODE_W'(30);
      SEG_V:      o_code = CODE_W'(31);
      SEG_W:      o_code = CODE_W'(32);
      SEG_X:      o_code = CODE_W'(33);
      SEG_Y:      o_code = CODE_W'(34);
      SEG_Z:      o_code = CODE_W'(35);
      SEG_NTILDE: o_code = CODE_W'(CODE_NTILDE);
      default:    o_code = CODE_W'(CODE_UNKNOWN);
    endcase
  end

endmodule

// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder: samples a multiplexed 14-segment scan bus, decodes each
// digit and commits a whole frame only when digits arrive in strict order.
// Optional macro SEG14_MSG_MATCH_EN adds the registered compare against
// EXPECT_MSG on o_msg_match; without it o_msg_match is tied low.
module seg14_scan_decoder
  import seg14_pkg::*;
#(
  parameter int NUM_DIGITS = 12,
  parameter int CODE_W     = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_DIGITS-1:0] i_sel,
  input  logic [13:0]           i_segm,
  input  logic [3:0]            i_rd_addr,
  output logic [CODE_W-1:0]     o_rd_data,
  output logic                  o_frame_valid,
  output logic                  o_seq_err,
  output logic                  o_unk_seen,
  output logic                  o_msg_match
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] SEL_ONE   = NUM_DIGITS'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]            ADDR_LAST = 4'(NUM_DIGITS - 1);
  localparam logic [CODE_W-1:0]     SPACE_C   = CODE_W'(CODE_SPACE);
  localparam logic [CODE_W-1:0]     UNKNOWN_C = CODE_W'(CODE_UNKNOWN);

  logic [NUM_DIGITS-1:0] r_sel;
  logic [13:0]           r_segm;
  logic [CODE_W-1:0]     w_code;
  logic                  w_selIdle;
  logic                  w_selOne;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_nextIdx;
  logic                  w_commit;
  logic                  w_newUnk;
  logic [CODE_W-1:0]     w_newFrame [NUM_DIGITS];

  state_t                r_state;
  logic [IDX_W-1:0]      r_lastIdx;
  logic [13:0]           r_heldSeg;
  logic [CODE_W-1:0]     r_shadow    [NUM_DIGITS];
  logic [CODE_W-1:0]     r_committed [NUM_DIGITS];
  logic [CODE_W-1:0]     r_rdData;
  logic                  r_frameValid;
  logic                  r_seqErr;
  logic                  r_unkSeen;

  // Single input register stage; every decision below looks at these copies
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel  <= '0;
      r_segm <= SEG_BLANK;
    end else begin
      r_sel  <= i_sel;
      r_segm <= i_segm;
    end
  end

  seg14_char_decode #(
    .CODE_W (CODE_W)
  ) u_decode (
    .i_segm (r_segm),
    .o_code (w_code)
  );

  // Classify the registered select: idle, one-hot (with its index) or invalid
  always_comb begin
    w_selIdle = (r_sel == '0);
    w_selOne  = !w_selIdle && ((r_sel & (r_sel - SEL_ONE)) == '0);
    w_idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_sel[i]) w_idx = IDX_W'(i);
    end
    w_nextIdx = r_lastIdx + IDX_W'(1);
    w_commit  = (r_state == ASSEMBLE) && w_selOne &&
                (w_idx != r_lastIdx) && (w_idx == w_nextIdx) &&
                (w_idx == IDX_LAST);
  end

  // Frame as it would be committed: shadow with the final digit's fresh decode
  always_comb begin
    w_newUnk = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_newFrame[i] = r_shadow[i];
    end
    w_newFrame[NUM_DIGITS-1] = w_code;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_newFrame[i] == UNKNOWN_C) w_newUnk = 1'b1;
    end
  end

  // Scan-order FSM: assembles the shadow frame and commits it on the last digit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= HUNT;
      r_lastIdx    <= '0;
      r_heldSeg    <= SEG_BLANK;
      r_frameValid <= 1'b0;
      r_seqErr     <= 1'b0;
      r_unkSeen    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i]    <= SPACE_C;
        r_committed[i] <= SPACE_C;
      end
    end else begin
      r_frameValid <= 1'b0;
      r_seqErr     <= 1'b0;
      if (!w_selIdle) begin
        case (r_state)
          HUNT: begin
            if (!w_selOne) begin
              r_seqErr <= 1'b1;
            end else if (w_idx == '0) begin
              r_shadow[0] <= w_code;
              r_lastIdx   <= '0;
              r_heldSeg   <= r_segm;
              r_state     <= ASSEMBLE;
            end
          end
          ASSEMBLE: begin
            if (w_selOne && (w_idx == r_lastIdx)) begin
              if (r_segm != r_heldSeg) begin
                r_shadow[w_idx] <= w_code;
                r_heldSeg       <= r_segm;
              end
            end else if (w_commit) begin
              for (int i = 0; i < NUM_DIGITS; i++) begin
                r_committed[i] <= w_newFrame[i];
              end
              r_frameValid <= 1'b1;
              r_unkSeen    <= w_newUnk;
              r_state      <= HUNT;
            end else if (w_selOne && (w_idx == w_nextIdx)) begin
              r_shadow[w_idx] <= w_code;
              r_lastIdx       <= w_idx;
              r_heldSeg       <= r_segm;
            end else begin
              r_seqErr <= 1'b1;
              if (w_selOne && (w_idx == '0)) begin
                r_shadow[0] <= w_code;
                r_lastIdx   <= '0;
                r_heldSeg   <= r_segm;
                r_state     <= ASSEMBLE;
              end else begin
                r_state <= HUNT;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  // Registered read port over the committed buffer; out-of-range reads blank
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdData <= SPACE_C;
    end else if (i_rd_addr <= ADDR_LAST) begin
      r_rdData <= r_committed[i_rd_addr];
    end else begin
      r_rdData <= SPACE_C;
    end
  end

`ifdef SEG14_MSG_MATCH_EN
  logic w_newMatch;
  logic r_msgMatch;

  // Compare the frame about to commit with the expected message
  always_comb begin
    w_newMatch = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_newFrame[i] != CODE_W'(EXPECT_MSG[i])) w_newMatch = 1'b0;
    end
  end

  // Match flag only moves on a commit so it always describes the visible frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_msgMatch <= 1'b0;
    end else if (w_commit) begin
      r_msgMatch <= w_newMatch;
    end
  end

  assign o_msg_match = r_msgMatch;
`else
  assign o_msg_match = 1'b0;
`endif

  assign o_rd_data     = r_rdData;
  assign o_frame_valid = r_frameValid;
  assign o_seq_err     = r_seqErr;
  assign o_unk_seen    = r_unkSeen;

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// tb_seg14_scan_decoder: directed self-checking bench for seg14_scan_decoder.
// Honours SEG14_MSG_MATCH_EN when choosing the expected o_msg_match value.
module tb_seg14_scan_decoder;

`ifdef SEG14_MSG_MATCH_EN
  localparam int MATCH_EXP = 1;
`else
  localparam int MATCH_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] sel;
  logic [13:0] segm;
  logic [3:0]  rdAddr;
  logic [5:0]  rdData;
  logic        frameValid;
  logic        seqErr;
  logic        unkSeen;
  logic        msgMatch;

  int checks   = 0;
  int failures = 0;
  int fvCount  = 0;
  int errCount = 0;

  logic [13:0] patMsg [12];
  logic [13:0] patCnt [12];
  logic [13:0] curPat [12];

  seg14_scan_decoder #(
    .NUM_DIGITS (12),
    .CODE_W     (6)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_sel         (sel),
    .i_segm        (segm),
    .i_rd_addr     (rdAddr),
    .o_rd_data     (rdData),
    .o_frame_valid (frameValid),
    .o_seq_err     (seqErr),
    .o_unk_seen    (unkSeen),
    .o_msg_match   (msgMatch)
  );

  // 10-unit clock period
  always #5 clk = ~clk;

  // Count pulses mid-cycle so the checks can compare totals between phases
  always @(negedge clk) begin
    if (frameValid) fvCount++;
    if (seqErr)     errCount++;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int first, input int last, input int hold);
    for (int d = first; d <= last; d++) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        sel  = 12'b1 << d;
        segm = curPat[d];
      end
    end
  endtask

  task automatic driveIdle(input int n);
    repeat (n) begin
      @(negedge clk);
      sel  = '0;
      segm = '0;
    end
  endtask

  task automatic readCheck(input string tag, input int addr, input int expected);
    @(negedge clk);
    rdAddr = 4'(addr);
    @(negedge clk);
    checkOutput(tag, 32'(rdData), 32'(expected));
  endtask

  initial begin
    // "BROTHING1201"
    patMsg[0]  = 14'b11110001010010;
    patMsg[1]  = 14'b11001111000001;
    patMsg[2]  = 14'b11111100000000;
    patMsg[3]  = 14'b10000000010010;
    patMsg[4]  = 14'b01101111000000;
    patMsg[5]  = 14'b10010000010010;
    patMsg[6]  = 14'b01101100100001;
    patMsg[7]  = 14'b10111101000000;
    patMsg[8]  = 14'b01100000001000;
    patMsg[9]  = 14'b11011011000000;
    patMsg[10] = 14'b11111100001100;
    patMsg[11] = 14'b01100000001000;
    // "0123456789AB"
    patCnt[0]  = 14'b11111100001100;
    patCnt[1]  = 14'b01100000001000;
    patCnt[2]  = 14'b11011011000000;
    patCnt[3]  = 14'b11110001000000;
    patCnt[4]  = 14'b01100111000000;
    patCnt[5]  = 14'b10110111000000;
    patCnt[6]  = 14'b10111111000000;
    patCnt[7]  = 14'b11100000000000;
    patCnt[8]  = 14'b11111111000000;
    patCnt[9]  = 14'b11110111000000;
    patCnt[10] = 14'b11101111000000;
    patCnt[11] = 14'b11110001010010;

    rst    = 1'b1;
    sel    = '0;
    segm   = '0;
    rdAddr = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_fv",     32'(frameValid), 0);
    checkOutput("rst_seqerr", 32'(seqErr),     0);
    checkOutput("rst_unk",    32'(unkSeen),    0);
    checkOutput("rst_match",  32'(msgMatch),   0);
    checkOutput("rst_rd0",    32'(rdData),     37);
    rst = 1'b0;
    readCheck("rst_rd11", 11, 37);

    // Clean frame with exact commit timing
    curPat = patMsg;
    applyStimulus(0, 11, 1);
    @(negedge clk);
    sel  = '0;
    segm = '0;
    checkOutput("fv_early",  32'(frameValid), 0);
    @(negedge clk);
    checkOutput("fv_pulse",  32'(frameValid), 1);
    @(negedge clk);
    checkOutput("fv_single", 32'(frameValid), 0);
    readCheck("msg_rd0",  0,  11);
    readCheck("msg_rd8",  8,  1);
    readCheck("msg_rd3",  3,  29);
    readCheck("msg_rd12", 12, 37);
    checkOutput("msg_match", 32'(msgMatch), 32'(MATCH_EXP));
    checkOutput("msg_unk",   32'(unkSeen),  0);
    #1;
    checkOutput("msg_fvcount",  32'(fvCount),  1);
    checkOutput("msg_errcount", 32'(errCount), 0);

    // Out-of-order jump 2 -> 5 aborts the frame
    curPat = patCnt;
    applyStimulus(0, 2, 1);
    @(negedge clk);
    sel  = 12'b1 << 5;
    segm = patCnt[5];
    driveIdle(4);
    #1;
    checkOutput("jump_errcount", 32'(errCount), 1);
    checkOutput("jump_fvcount",  32'(fvCount),  1);
    readCheck("jump_rd0", 0, 11);
    readCheck("jump_rd1", 1, 27);

    // Clean counting frame afterwards
    applyStimulus(0, 11, 1);
    driveIdle(3);
    #1;
    checkOutput("cnt_fvcount", 32'(fvCount), 2);
    readCheck("cnt_rd0",  0,  0);
    readCheck("cnt_rd5",  5,  5);
    readCheck("cnt_rd11", 11, 11);
    checkOutput("cnt_match", 32'(msgMatch), 0);
    checkOutput("cnt_unk",   32'(unkSeen),  0);

    // Two-hot select mid-frame; remaining digits are ignored in HUNT
    curPat = patMsg;
    applyStimulus(0, 3, 1);
    @(negedge clk);
    sel  = 12'b000000000011;
    segm = patMsg[4];
    applyStimulus(4, 11, 1);
    driveIdle(3);
    #1;
    checkOutput("bad_errcount", 32'(errCount), 2);
    checkOutput("bad_fvcount",  32'(fvCount),  2);
    readCheck("bad_rd0", 0, 0);

    // Long idle gap mid-frame is tolerated
    applyStimulus(0, 5, 1);
    driveIdle(10);
    applyStimulus(6, 11, 1);
    driveIdle(3);
    #1;
    checkOutput("gap_errcount", 32'(errCount), 2);
    checkOutput("gap_fvcount",  32'(fvCount),  3);
    readCheck("gap_rd7", 7, 16);
    checkOutput("gap_match", 32'(msgMatch), 32'(MATCH_EXP));

    // Slow scan: each digit held three cycles
    curPat = patCnt;
    applyStimulus(0, 11, 3);
    driveIdle(3);
    #1;
    checkOutput("slow_fvcount",  32'(fvCount),  4);
    checkOutput("slow_errcount", 32'(errCount), 2);
    readCheck("slow_rd4",  4,  4);
    readCheck("slow_rd10", 10, 10);

    // Unknown pattern on digit 4
    curPat    = patMsg;
    curPat[4] = 14'b00000000000001;
    applyStimulus(0, 11, 1);
    driveIdle(3);
    #1;
    checkOutput("unk_fvcount", 32'(fvCount), 5);
    readCheck("unk_rd4", 4, 63);
    readCheck("unk_rd5", 5, 18);
    checkOutput("unk_flag",  32'(unkSeen),  1);
    checkOutput("unk_match", 32'(msgMatch), 0);

    // Next clean frame clears the sticky flag
    curPat = patMsg;
    applyStimulus(0, 11, 1);
    driveIdle(3);
    #1;
    checkOutput("clr_fvcount", 32'(fvCount),  6);
    checkOutput("clr_unk",     32'(unkSeen),  0);
    checkOutput("clr_match",   32'(msgMatch), 32'(MATCH_EXP));

    // Reset while digit 6 is in flight
    curPat = patCnt;
    applyStimulus(0, 6, 1);
    @(negedge clk);
    rst  = 1'b1;
    sel  = '0;
    segm = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    driveIdle(4);
    #1;
    checkOutput("mrst_fvcount", 32'(fvCount),    6);
    checkOutput("mrst_fv",      32'(frameValid), 0);
    checkOutput("mrst_seqerr",  32'(seqErr),     0);
    checkOutput("mrst_unk",     32'(unkSeen),    0);
    checkOutput("mrst_match",   32'(msgMatch),   0);
    for (int a = 0; a < 12; a++) begin
      readCheck($sformatf("mrst_rd%0d", a), a, 37);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
